clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed-N divider.
- Generates a divided-clock-enable waveform (clkout) and a period-start strobe (tick) from the system clock.
- Divisor and duty mode are reloadable on the fly. Changes take effect only at period boundaries, so no runt or glitch periods occur.
- Graceful start and stop: always emits whole periods. Feeds timers, baud generators and LED blink logic.

Parameters:
- WIDTH, 4, width of divisor and counter; N range 0..2^WIDTH-1.
- N, 12, divisor loaded at reset.
- MODE, 0, duty mode loaded at reset (0 = ~50% duty, 1 = single-cycle pulse).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  run request; level sensitive.
- div_load  in  1  one-cycle strobe; captures div_n and div_mode.
- div_n  in  WIDTH  new divisor.
- div_mode  in  1  new duty mode.
- div_pend  out  1  captured divisor/mode not yet applied.
- clkout  out  1  divided waveform, registered.
- tick  out  1  high in first cycle of every period (cnt==0 while running), registered.
- cnt  out  WIDTH  current phase, 0..N_act-1, registered.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low, sampled only on posedge clk.
- Reset values:
  - state=IDLE, cnt=0, clkout=0, tick=0, div_pend=0.
  - N_act=N, mode_act=MODE; pending registers are discarded.
- Reset asserted mid-period takes effect on that edge. No completion of the current period.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cnt=0, clkout=0, tick=0.
  - If en=1 and N_act!=0: go to RUN; the next cycle shows cnt=0, tick=1 and clkout=f(0).
  - Latency from en rising to first tick is one cycle.
- RUN:
  - Every edge: cnt <= (cnt==N_act-1) ? 0 : cnt+1.
  - The edge where cnt wraps to 0 is the period boundary.
  - en=0 sampled: go to DRAIN; counting continues unchanged.
- DRAIN:
  - Counts like RUN.
  - en=1 sampled: back to RUN; the period is uninterrupted.
  - At the boundary edge with en still 0: go to IDLE; outputs become 0 and no tick is issued.
- Output decode, registered so that clkout/tick match cnt in the same cycle:
  - mode 0: clkout=1 iff cnt < N_act>>1. N=12 gives 6 high/6 low; N=5 gives 2 high/3 low.
  - mode 1: clkout=1 iff cnt==0.
  - N_act==1: cnt stays 0, tick=1 and clkout=1 every running cycle in both modes.
  - N_act==2: mode 0 gives 1 high/1 low.
  - tick=1 iff running (RUN/DRAIN) and cnt==0.
- Reload:
  - div_load=1 captures div_n and div_mode into pending registers and sets div_pend=1. The last load wins.
  - Applied at the next boundary edge strictly after the capture edge: N_act/mode_act take the pending values and div_pend clears.
  - A load on the same edge as a boundary is applied at the following boundary; div_pend stays 1.
  - In IDLE, a load is applied on the capture edge; div_pend remains 0.
  - Applying N=0: at that boundary go to IDLE; en is ignored until a nonzero N is applied.
- Counter never exceeds N_act-1. Wrap compare uses the WIDTH-bit N_act-1, valid since N_act>=1 when running.

Test Plan:
- Reset 25 ns, en=1, clk 20 ns, N=12 -> tick one cycle after en; clkout 6 cycles high, 6 low; tick every 12 cycles (240 ns); cnt 0..11.
- Load div_n=5 mode 0 while cnt=4 -> div_pend=1 until cnt 11->0 edge. The following periods are 5 cycles, clkout 2 high/3 low.
- Load div_n=4 div_mode=1 in IDLE, then en=1 -> div_pend stays 0; clkout is a one-cycle pulse at cnt=0 every 4 cycles, coincident with tick.
- en drops at cnt=3 (N=12) -> counting continues to cnt=11, then IDLE with clkout=0 and no tick. Re-raising en at cnt=8 during DRAIN -> no gap; next tick at cnt wrap.
- rst_n low at cnt=7 after a pending load of N=3 -> next cycle cnt=0, clkout=0, div_pend=0, N_act=12. The pending 3 is never applied.
- Boundary divisors: N=1 -> clkout=1, tick every cycle. N=2 -> clkout alternates 1/0. Applying N=0 -> IDLE; en=1 gives no activity until N=6 is loaded.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: emits a divided clock-enable waveform
// (clkout), a period-start strobe (tick) and the current phase (cnt).
// Latency: one cycle from en sampled high in IDLE to the first tick.
// Backpressure: none; divisor/mode reloads queue in one pending slot and
// apply only at period boundaries.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   en        level-sensitive run request
//   div_load  one-cycle strobe capturing div_n / div_mode
//   div_n     new divisor (0 stops the divider at the next boundary)
//   div_mode  new duty mode (0 = ~50% duty, 1 = single-cycle pulse)
//   div_pend  a captured divisor/mode is waiting for a boundary
//   clkout    divided waveform, registered
//   tick      high in the first cycle of every period, registered
//   cnt       current phase 0..N_act-1, registered
module clk_div_prog #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 12,
  parameter logic        MODE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_n,
  input  logic             div_mode,
  output logic             div_pend,
  output logic             clkout,
  output logic             tick,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic             mode_act_q, mode_act_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_n_q, pend_n_d;
  logic             pend_mode_q, pend_mode_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             boundary;
  logic             run_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_act_d     = n_act_q;
    mode_act_d  = mode_act_q;
    pend_d      = pend_q;
    pend_n_d    = pend_n_q;
    pend_mode_d = pend_mode_q;
    boundary    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Idle has no period in flight, so every edge acts as a boundary:
        // a fresh load wins, otherwise a leftover pending value applies now.
        if (div_load) begin
          n_act_d    = div_n;
          mode_act_d = div_mode;
        end else if (pend_q) begin
          n_act_d    = pend_n_q;
          mode_act_d = pend_mode_q;
        end
        pend_d = 1'b0;
        cnt_d  = '0;
        if (en && (n_act_d != '0)) begin
          state_d = S_RUN;
        end
      end

      default: begin
        // n_act_q >= 1 whenever running, so the WIDTH-bit N-1 never wraps.
        boundary = (cnt_q == (n_act_q - WIDTH'(1)));
        cnt_d    = boundary ? '0 : cnt_q + WIDTH'(1);

        // Apply the older pending value first; a load on this same edge
        // then refills the slot and waits for the following boundary.
        if (boundary && pend_q) begin
          n_act_d    = pend_n_q;
          mode_act_d = pend_mode_q;
          pend_d     = 1'b0;
        end
        if (div_load) begin
          pend_n_d    = div_n;
          pend_mode_d = div_mode;
          pend_d      = 1'b1;
        end

        if (state_q == S_RUN) begin
          state_d = en ? S_RUN : S_DRAIN;
        end else begin
          state_d = en ? S_RUN : (boundary ? S_IDLE : S_DRAIN);
        end
        if (boundary && (n_act_d == '0)) begin
          state_d = S_IDLE;
        end
        if (state_d == S_IDLE) begin
          cnt_d = '0;
        end
      end
    endcase

    // Decode from next-state values so the registered outputs line up with
    // the registered cnt in the same cycle.
    run_d  = (state_d != S_IDLE);
    tick_d = run_d && (cnt_d == '0);
    if (mode_act_d) begin
      clkout_d = run_d && (cnt_d == '0);
    end else begin
      clkout_d = run_d && ((cnt_d < (n_act_d >> 1)) || (n_act_d == WIDTH'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_act_q     <= WIDTH'(N);
      mode_act_q  <= MODE;
      pend_q      <= 1'b0;
      pend_n_q    <= '0;
      pend_mode_q <= 1'b0;
      clkout_q    <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_act_q     <= n_act_d;
      mode_act_q  <= mode_act_d;
      pend_q      <= pend_d;
      pend_n_q    <= pend_n_d;
      pend_mode_q <= pend_mode_d;
      clkout_q    <= clkout_d;
      tick_q      <= tick_d;
    end
  end

  assign div_pend = pend_q;
  assign clkout   = clkout_q;
  assign tick     = tick_q;
  assign cnt      = cnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random traffic
// compared every cycle against a period-level behavioural model.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_clk_div_prog;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         div_load;
  logic [W-1:0] div_n;
  logic         div_mode;
  logic         div_pend;
  logic         clkout;
  logic         tick;
  logic [W-1:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: is a period in progress, has a stop been requested,
  // phase within the period, active divisor/mode and the one-deep reload slot.
  int m_active, m_stop, m_ph, m_n, m_md, m_pend, m_pn, m_pm;

  clk_div_prog #(.WIDTH(W), .N(12), .MODE(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_load (div_load),
    .div_n    (div_n),
    .div_mode (div_mode),
    .div_pend (div_pend),
    .clkout   (clkout),
    .tick     (tick),
    .cnt      (cnt)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, fed with the sampled inputs.
  task automatic model_step(input int e, input int ld, input int ldn, input int ldm, input int r);
    int at_end;
    if (r == 0) begin
      m_active = 0; m_stop = 0; m_ph = 0;
      m_n = 12; m_md = 0; m_pend = 0;
    end else if (m_active == 0) begin
      if (ld != 0) begin
        m_n = ldn; m_md = ldm;
      end else if (m_pend != 0) begin
        m_n = m_pn; m_md = m_pm;
      end
      m_pend = 0;
      m_ph   = 0;
      if (e != 0 && m_n != 0) begin
        m_active = 1; m_stop = 0;
      end
    end else begin
      at_end = (m_ph == m_n - 1);
      m_ph = at_end ? 0 : m_ph + 1;
      if (at_end && m_pend != 0) begin
        m_n = m_pn; m_md = m_pm; m_pend = 0;
      end
      if (ld != 0) begin
        m_pn = ldn; m_pm = ldm; m_pend = 1;
      end
      if (m_stop != 0 && e == 0 && at_end) m_active = 0;
      else m_stop = (e == 0);
      if (at_end && m_n == 0) m_active = 0;
      if (m_active == 0) m_ph = 0;
    end
  endtask

  task automatic compare_outputs();
    int exp_clk;
    if (m_active == 0) exp_clk = 0;
    else if (m_md != 0) exp_clk = (m_ph == 0);
    else exp_clk = (m_n == 1) || (m_ph < m_n / 2);
    check_eq("cnt", int'(cnt), m_ph);
    check_eq("tick", int'(tick), (m_active != 0 && m_ph == 0) ? 1 : 0);
    check_eq("clkout", int'(clkout), exp_clk);
    check_eq("div_pend", int'(div_pend), m_pend);
  endtask

  task automatic cyc(input logic e, input logic ld, input logic [W-1:0] dn, input logic dm, input logic r);
    en = e; div_load = ld; div_n = dn; div_mode = dm; rst_n = r;
    @(posedge clk);
    model_step(int'(e), int'(ld), int'(dn), int'(dm), int'(r));
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_cycles(input logic e, input int k);
    for (int i = 0; i < k; i++) cyc(e, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Advance until the model's phase reaches target (bounded).
  task automatic run_until(input int target, input logic e);
    for (int i = 0; i < 40 && m_ph != target; i++) cyc(e, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic e_r;
    m_pn = 0; m_pm = 0;
    en = 1'b0; div_load = 1'b0; div_n = '0; div_mode = 1'b0; rst_n = 1'b0;

    // Reset, then N=12 run: 6 high / 6 low, tick every 12 cycles.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle_cycles(1'b1, 30);

    // Reload to N=5 mode 0 at cnt=4; applies at the 11->0 boundary.
    run_until(4, 1'b1);
    cyc(1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
    idle_cycles(1'b1, 20);

    // Stop, then load N=4 pulse mode while idle.
    idle_cycles(1'b0, 12);
    cyc(1'b0, 1'b1, 4'd4, 1'b1, 1'b1);
    idle_cycles(1'b1, 13);

    // Back to N=12; drop en at cnt=3 and let it drain to idle.
    idle_cycles(1'b0, 8);
    cyc(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    run_until(3, 1'b1);
    idle_cycles(1'b0, 14);

    // Drop at cnt=3, re-raise at cnt=8 during drain: no gap.
    idle_cycles(1'b1, 1);
    run_until(3, 1'b1);
    run_until(8, 1'b0);
    idle_cycles(1'b1, 20);

    // Reset at cnt=7 with N=3 pending: pending value is discarded.
    run_until(6, 1'b1);
    cyc(1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle_cycles(1'b1, 14);

    // Boundary divisors N=1, N=2, then N=0 stops until N=6 is loaded.
    cyc(1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
    idle_cycles(1'b1, 14);
    cyc(1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
    idle_cycles(1'b1, 8);
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    idle_cycles(1'b1, 10);
    cyc(1'b1, 1'b1, 4'd6, 1'b0, 1'b1);
    idle_cycles(1'b1, 15);

    // Random traffic: bursty en, sporadic reloads and resets.
    e_r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 4) e_r = ~e_r;
      cyc(e_r,
          ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
          W'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
